// File: rtl/fifo_pkg.sv
// fifo_pkg: shared helpers and read-mode constants for the FIFO family
package fifo_pkg;

    localparam int FIFO_MODE_STD  = 0;
    localparam int FIFO_MODE_FWFT = 1;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) r = ((1 << i) < value) ? i + 1 : r;
        return r;
    endfunction

endpackage

// File: rtl/sync_fifo_mem.sv
// sync_fifo_mem: register-array storage, one synchronous write port and one asynchronous read port
module sync_fifo_mem
    import fifo_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int FIFO_DEPTH = 6,
    parameter int ADDR_WIDTH = 3
) (
    input  logic                  clk,
    input  logic                  wr_en_i,
    input  logic [ADDR_WIDTH-1:0] waddr_i,
    input  logic [DATA_WIDTH-1:0] wdata_i,
    input  logic [ADDR_WIDTH-1:0] raddr_i,
    output logic [DATA_WIDTH-1:0] rdata_o
);

    logic [DATA_WIDTH-1:0] mem_q [FIFO_DEPTH];

    // storage is deliberately left unreset so it can later become an SRAM macro
    always_ff @(posedge clk) begin
        if (wr_en_i) mem_q[waddr_i] <= wdata_i;
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/sync_fifo.sv
// sync_fifo: single-clock FIFO with occupancy count, threshold flags, error pulses and selectable FWFT read
module sync_fifo
    import fifo_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int FIFO_DEPTH = 6,
    parameter int FWFT       = FIFO_MODE_STD,
    parameter int AF_THRESH  = FIFO_DEPTH - 1,
    parameter int AE_THRESH  = 1
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              wr_valid,
    input  logic [DATA_WIDTH-1:0]             wr_data,
    input  logic                              rd_ready,
    output logic                              rd_valid,
    output logic [DATA_WIDTH-1:0]             rd_data,
    output logic                              full,
    output logic                              empty,
    output logic                              almost_full,
    output logic                              almost_empty,
    output logic [clog2(FIFO_DEPTH+1)-1:0]    count,
    output logic                              overflow,
    output logic                              underflow
);

    localparam int PTR_WIDTH = (clog2(FIFO_DEPTH) < 1) ? 1 : clog2(FIFO_DEPTH);
    localparam int CNT_WIDTH = clog2(FIFO_DEPTH + 1);
    localparam logic [PTR_WIDTH-1:0] PTR_LAST = PTR_WIDTH'(FIFO_DEPTH - 1);

    logic [PTR_WIDTH-1:0]  wptr_q, wptr_d, rptr_q, rptr_d;
    logic [CNT_WIDTH-1:0]  count_q, count_d;
    logic                  ovf_q, udf_q;
    logic                  w_en, r_en;
    logic [DATA_WIDTH-1:0] mem_rdata;

    // flags decode only from the registered count, so no input reaches them combinationally
    assign full         = count_q == CNT_WIDTH'(FIFO_DEPTH);
    assign empty        = count_q == '0;
    assign almost_full  = count_q >= CNT_WIDTH'(AF_THRESH);
    assign almost_empty = count_q <= CNT_WIDTH'(AE_THRESH);
    assign count        = count_q;
    assign overflow     = ovf_q;
    assign underflow    = udf_q;

    assign w_en = wr_valid && !full;
    assign r_en = rd_ready && !empty;

    // next-state: pointers wrap explicitly at FIFO_DEPTH-1 so any depth works
    always_comb begin
        wptr_d  = w_en ? ((wptr_q == PTR_LAST) ? '0 : wptr_q + PTR_WIDTH'(1)) : wptr_q;
        rptr_d  = r_en ? ((rptr_q == PTR_LAST) ? '0 : rptr_q + PTR_WIDTH'(1)) : rptr_q;
        count_d = (w_en && !r_en) ? count_q + CNT_WIDTH'(1) :
                  (r_en && !w_en) ? count_q - CNT_WIDTH'(1) : count_q;
    end

    // pointer, occupancy and error-pulse state
    always_ff @(posedge clk) begin
        if (rst) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
            ovf_q   <= 1'b0;
            udf_q   <= 1'b0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
            ovf_q   <= wr_valid && full;
            udf_q   <= (FWFT != FIFO_MODE_FWFT) && rd_ready && empty;
        end
    end

    sync_fifo_mem #(
        .DATA_WIDTH (DATA_WIDTH),
        .FIFO_DEPTH (FIFO_DEPTH),
        .ADDR_WIDTH (PTR_WIDTH)
    ) u_mem (
        .clk     (clk),
        .wr_en_i (w_en),
        .waddr_i (wptr_q),
        .wdata_i (wr_data),
        .raddr_i (rptr_q),
        .rdata_o (mem_rdata)
    );

    if (FWFT == FIFO_MODE_FWFT) begin : g_fwft
        // head entry is presented directly; masked while empty so stale memory never shows
        assign rd_valid = !empty;
        assign rd_data  = empty ? '0 : mem_rdata;
    end else begin : g_std
        logic                  rd_valid_q;
        logic [DATA_WIDTH-1:0] rd_data_q;
        // registered read: data captured on pop and held until the next pop
        always_ff @(posedge clk) begin
            if (rst) begin
                rd_valid_q <= 1'b0;
                rd_data_q  <= '0;
            end else begin
                rd_valid_q <= r_en;
                rd_data_q  <= r_en ? mem_rdata : rd_data_q;
            end
        end
        assign rd_valid = rd_valid_q;
        assign rd_data  = rd_data_q;
    end

endmodule

// File: tb/tb_sync_fifo.sv
// tb_sync_fifo: queue-model and directed checks of standard and FWFT sync_fifo instances
module tb_sync_fifo;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       wr_valid = 1'b0;
    logic [7:0] wr_data = 8'h00;
    logic       rd_ready = 1'b0;

    logic       s_rv, s_full, s_empty, s_af, s_ae, s_ovf, s_udf;
    logic [7:0] s_rd;
    logic [2:0] s_count;
    logic       f_rv, f_full, f_empty, f_af, f_ae, f_ovf, f_udf;
    logic [7:0] f_rd;
    logic [2:0] f_count;

    int total = 0;
    int bad = 0;
    bit chk_en = 1'b0;

    logic [7:0] sq[$];
    logic [7:0] fq[$];
    logic       m_s_rv = 1'b0, m_s_ovf = 1'b0, m_s_udf = 1'b0, m_f_ovf = 1'b0;
    logic [7:0] m_s_rd = 8'h00;

    always #5 clk = ~clk;

    sync_fifo #(.DATA_WIDTH(8), .FIFO_DEPTH(6), .FWFT(0), .AF_THRESH(5), .AE_THRESH(1)) u_std (
        .clk(clk), .rst(rst), .wr_valid(wr_valid), .wr_data(wr_data), .rd_ready(rd_ready),
        .rd_valid(s_rv), .rd_data(s_rd), .full(s_full), .empty(s_empty),
        .almost_full(s_af), .almost_empty(s_ae), .count(s_count),
        .overflow(s_ovf), .underflow(s_udf)
    );

    sync_fifo #(.DATA_WIDTH(8), .FIFO_DEPTH(6), .FWFT(1), .AF_THRESH(5), .AE_THRESH(1)) u_fw (
        .clk(clk), .rst(rst), .wr_valid(wr_valid), .wr_data(wr_data), .rd_ready(rd_ready),
        .rd_valid(f_rv), .rd_data(f_rd), .full(f_full), .empty(f_empty),
        .almost_full(f_af), .almost_empty(f_ae), .count(f_count),
        .overflow(f_ovf), .underflow(f_udf)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // one clock: apply inputs, let the edge happen, advance the queue model, settle
    task automatic tick(input logic r, input logic v, input logic [7:0] d, input logic rr);
        bit s_push, s_pop, f_push, f_pop;
        rst = r; wr_valid = v; wr_data = d; rd_ready = rr;
        @(posedge clk);
        if (r) begin
            sq.delete(); fq.delete();
            m_s_rv = 0; m_s_rd = 0; m_s_ovf = 0; m_s_udf = 0; m_f_ovf = 0;
        end else begin
            s_push = v && sq.size() < 6;
            s_pop  = rr && sq.size() > 0;
            m_s_ovf = v && sq.size() == 6;
            m_s_udf = rr && sq.size() == 0;
            m_s_rv  = s_pop;
            if (s_pop) m_s_rd = sq.pop_front();
            if (s_push) sq.push_back(d);
            f_push = v && fq.size() < 6;
            f_pop  = rr && fq.size() > 0;
            m_f_ovf = v && fq.size() == 6;
            if (f_pop) void'(fq.pop_front());
            if (f_push) fq.push_back(d);
        end
        #1;
    endtask

    // every cycle, compare both instances against the queue model
    always @(negedge clk) begin
        if (chk_en) begin
            chk("s_count", s_count, sq.size());
            chk("s_full", s_full, sq.size() == 6);
            chk("s_empty", s_empty, sq.size() == 0);
            chk("s_af", s_af, sq.size() >= 5);
            chk("s_ae", s_ae, sq.size() <= 1);
            chk("s_rv", s_rv, m_s_rv);
            chk("s_rd", s_rd, m_s_rd);
            chk("s_ovf", s_ovf, m_s_ovf);
            chk("s_udf", s_udf, m_s_udf);
            chk("f_count", f_count, fq.size());
            chk("f_full", f_full, fq.size() == 6);
            chk("f_empty", f_empty, fq.size() == 0);
            chk("f_af", f_af, fq.size() >= 5);
            chk("f_ae", f_ae, fq.size() <= 1);
            chk("f_rv", f_rv, fq.size() > 0);
            chk("f_rd", f_rd, fq.size() > 0 ? fq[0] : 8'h00);
            chk("f_ovf", f_ovf, m_f_ovf);
            chk("f_udf", f_udf, 1'b0);
        end
    end

    initial begin
        tick(1, 1, 8'h55, 1);
        tick(1, 1, 8'h55, 1);
        chk_en = 1'b1;
        chk("rst_count", s_count, 0);
        chk("rst_empty", s_empty, 1);
        chk("rst_full", s_full, 0);
        chk("rst_ae", s_ae, 1);
        chk("rst_rv", s_rv, 0);
        chk("rst_rd", s_rd, 8'h00);
        chk("rst_f_rv", f_rv, 0);
        tick(0, 0, 8'h00, 0);
        chk("rst_nowrite", s_count, 0);

        for (int i = 0; i < 7; i++) tick(0, 1, 8'h10 + 8'(i), 0);
        chk("fill_count", s_count, 6);
        chk("fill_full", s_full, 1);
        chk("fill_af", s_af, 1);
        chk("fill_ovf", s_ovf, 1);
        tick(0, 0, 8'h00, 0);
        chk("fill_ovf_drop", s_ovf, 0);
        chk("fill_f_head", f_rd, 8'h10);

        tick(0, 1, 8'h20, 1);
        chk("full_pp_count", s_count, 5);
        chk("full_pp_ovf", s_ovf, 1);
        chk("full_pp_rd", s_rd, 8'h10);
        chk("full_pp_rv", s_rv, 1);
        chk("full_pp_f_rd", f_rd, 8'h11);

        for (int i = 0; i < 5; i++) tick(0, 0, 8'h00, 1);
        chk("drain_rd", s_rd, 8'h15);
        chk("drain_empty", s_empty, 1);

        tick(0, 1, 8'h30, 1);
        chk("empty_pp_count", s_count, 1);
        chk("empty_pp_udf", s_udf, 1);
        chk("empty_pp_rv", s_rv, 0);
        chk("empty_pp_f_rd", f_rd, 8'h30);
        chk("empty_pp_f_udf", f_udf, 0);
        tick(0, 0, 8'h00, 1);
        chk("empty_pp_pop", s_rd, 8'h30);

        tick(0, 1, 8'hA5, 0);
        chk("fwft_rv", f_rv, 1);
        chk("fwft_rd", f_rd, 8'hA5);
        tick(0, 0, 8'h00, 1);
        chk("fwft_drained", f_count, 0);
        chk("fwft_std_rd", s_rd, 8'hA5);
        tick(0, 0, 8'h00, 1);
        chk("fwft_udf", f_udf, 0);
        chk("std_udf", s_udf, 1);
        tick(0, 0, 8'h00, 0);

        for (int i = 0; i < 20; i++) tick(0, 1, 8'h40 + 8'(i), i >= 3);
        chk("wrap_count", s_count, 3);
        chk("wrap_rd", s_rd, 8'h50);
        for (int i = 0; i < 3; i++) tick(0, 0, 8'h00, 1);
        chk("wrap_last", s_rd, 8'h53);

        for (int i = 0; i < 4; i++) tick(0, 1, 8'h61 + 8'(i), 0);
        chk("mid_count", s_count, 4);
        tick(1, 1, 8'h77, 1);
        chk("mid_rst_count", s_count, 0);
        chk("mid_rst_f_rv", f_rv, 0);
        tick(0, 1, 8'h3C, 0);
        chk("mid_f_rd", f_rd, 8'h3C);
        tick(0, 0, 8'h00, 1);
        chk("mid_rd", s_rd, 8'h3C);
        chk("mid_rv", s_rv, 1);
        tick(0, 0, 8'h00, 0);

        chk_en = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
